// File: rtl/terminate_pipeline_multi_if.sv
// terminate_pipeline_multi_if: issue-side and redirect-side handshake bundle for terminate_pipeline_multi.
interface terminate_pipeline_multi_if #(
    parameter int ADDR_W   = 16,
    parameter int FLAG_W   = 8,
    parameter int OFFSET_W = 8,
    parameter int TAG_W    = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [3:0]          opcode;
    logic [ADDR_W-1:0]   reg_base_val;
    logic [3:0]          flag_index;
    logic [FLAG_W-1:0]   flag_vals;
    logic [OFFSET_W-1:0] offset;
    logic [3:0]          immediate;
    logic [TAG_W-1:0]    in_tag;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic                out_taken;
    logic                out_is_term;
    logic [ADDR_W-1:0]   out_addr;
    logic [TAG_W-1:0]    out_tag;

    modport master (
        output in_valid, opcode, reg_base_val, flag_index, flag_vals, offset, immediate, in_tag,
               flush, out_ready,
        input  in_ready, out_valid, out_taken, out_is_term, out_addr, out_tag
    );

    modport slave (
        input  in_valid, opcode, reg_base_val, flag_index, flag_vals, offset, immediate, in_tag,
               flush, out_ready,
        output in_ready, out_valid, out_taken, out_is_term, out_addr, out_tag
    );
endinterface

// File: rtl/terminate_pipeline_multi.sv
// terminate_pipeline_multi: STAGES-deep elastic, flushable resolver of block-terminate target and taken bit.
// Define TERMINATE_STATS_EN to add taken/not-taken handshake counters.
module terminate_pipeline_multi #(
    parameter int ADDR_W   = 16,
    parameter int FLAG_W   = 8,
    parameter int OFFSET_W = 8,
    parameter int TAG_W    = 4,
    parameter int STAGES   = 2
) (
    input logic clk,
    input logic rst,
    terminate_pipeline_multi_if.slave bus
`ifdef TERMINATE_STATS_EN
    ,
    output logic [31:0] stat_taken,
    output logic [31:0] stat_not_taken
`endif
);
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("terminate_pipeline_multi: STAGES must be in 1..4");
    end

    logic              adv;
    logic              cond;
    logic              taken;
    logic              is_term;
    logic [ADDR_W-1:0] addr;
    logic              unused_imm;

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] tk;
    logic [STAGES-1:0] tm;
    logic [ADDR_W-1:0] ad [STAGES];
    logic [TAG_W-1:0]  tg [STAGES];

    assign adv          = !vld[STAGES-1] || bus.out_ready;
    assign bus.in_ready = adv;
    assign unused_imm   = ^bus.immediate[2:0];

    // Out-of-range flag indices read as a cleared flag.
    always_comb begin
        cond = 1'b0;
        for (int i = 0; i < FLAG_W; i++)
            if (int'(bus.flag_index) == i) cond = bus.flag_vals[i];
    end

    assign taken   = (bus.opcode == 4'b1111) | ((bus.opcode == 4'b1110) & (cond ^ bus.immediate[3]));
    assign is_term = bus.opcode[3:1] == 3'b111;
    assign addr    = bus.reg_base_val + ADDR_W'($signed(bus.offset));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            tk  <= '0;
            tm  <= '0;
            for (int i = 0; i < STAGES; i++) begin
                ad[i] <= '0;
                tg[i] <= '0;
            end
        end else begin
            if (bus.flush) begin
                vld <= '0;
            end else if (adv) begin
                vld[0] <= bus.in_valid;
                for (int i = 1; i < STAGES; i++) vld[i] <= vld[i-1];
            end
            if (adv) begin
                tk[0] <= taken;
                tm[0] <= is_term;
                ad[0] <= addr;
                tg[0] <= bus.in_tag;
                for (int i = 1; i < STAGES; i++) begin
                    tk[i] <= tk[i-1];
                    tm[i] <= tm[i-1];
                    ad[i] <= ad[i-1];
                    tg[i] <= tg[i-1];
                end
            end
        end
    end

    assign bus.out_valid   = vld[STAGES-1];
    assign bus.out_taken   = tk[STAGES-1];
    assign bus.out_is_term = tm[STAGES-1];
    assign bus.out_addr    = ad[STAGES-1];
    assign bus.out_tag     = tg[STAGES-1];

`ifdef TERMINATE_STATS_EN
    // Counted at the output handshake so flushed ops never contribute.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_taken     <= '0;
            stat_not_taken <= '0;
        end else if (bus.out_valid && bus.out_ready && bus.out_is_term) begin
            if (bus.out_taken) stat_taken <= stat_taken + 32'd1;
            else stat_not_taken <= stat_not_taken + 32'd1;
        end
    end
`endif
endmodule
